csr_host_port: RTL
==================

# csr_host_port

Host-side initiator for the CSR bus. It accepts CSR access requests from an external host, such as a debug link or a test harness, over a valid/ready handshake. It arbitrates those requests against the core's own CSR accesses and drives the shared CSR bus (enable, address, op, operands) to every `csr` instance. It captures the asynchronous read data as the pre-write value and returns it on a valid/ready response channel. A bounded-wait counter guarantees forward progress by stalling the core when host requests are starved.

## Interface
Parameters:
- `MaxWait`, default 15: PEND cycles the host may lose arbitration before `core_stall` forces a host slot.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  host request valid
- `req_ready`  out  1  block can accept a request
- `req_addr`  in  csr_addr_t  target CSR address
- `req_op`  in  csr_op_t  CSR operation
- `req_data`  in  word  rs1 operand for register ops
- `req_zimm`  in  r  immediate for the *I ops
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  host accepts response
- `rsp_data`  out  word  CSR value before the access
- `rsp_err`  out  1  request had an illegal op and no access was made
- `core_csr_enable`  in  1  core CSR access this cycle
- `core_csr_addr`  in  csr_addr_t  core address
- `core_csr_op`  in  csr_op_t  core op
- `core_rs1_zimm`  in  r  core zimm
- `core_rs1_data`  in  word  core rs1 data
- `csr_enable`  out  1  to CSR bus
- `csr_addr`  out  csr_addr_t  to CSR bus
- `csr_op`  out  csr_op_t  to CSR bus
- `rs1_zimm`  out  r  to CSR bus
- `rs1_data`  out  word  to CSR bus
- `csr_rdata`  in  word  OR-reduced `out` of all CSR instances (combinational)
- `core_stall`  out  1  freeze core this cycle

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, latch addr/op/data/zimm, clear the wait counter, go to PEND.
  - PEND: the host owns the bus if `!core_csr_enable`, or if the wait counter == MaxWait. Otherwise the counter increments and the state holds.
  - Host-owned PEND cycle: drive `csr_enable`=1 with the latched fields, capture `csr_rdata` into `rsp_data`, go to RESP.
  - RESP: `rsp_valid`=1 with `rsp_data`/`rsp_err` stable until `rsp_ready`, then go to IDLE.
- Illegal `req_op` (not CSRRW/S/C/WI/SI/CI): skip PEND. Go IDLE→RESP with `rsp_err`=1 and `rsp_data`=0; no bus activity.
- Bus mux:
  - When the host does not own the bus, the outputs pass through the core inputs unchanged.
  - When the host owns the bus, the outputs carry the host fields. `core_stall`=1 only if `core_csr_enable`=1 in that cycle.
- The core holds its CSR operands while `core_stall` is asserted, and its access completes in a following cycle. The block does not buffer core accesses.
- The wait counter is $clog2(MaxWait+1) bits and saturates at MaxWait.
- MaxWait=0: the first contested PEND cycle stalls the core.
- `req_ready`=0 in PEND and RESP, so there is one outstanding request at most.

## Timing
- Reset values:
  - `req_ready`=1; `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
  - `core_stall`=0; state IDLE; counter 0.
  - Bus outputs follow the core inputs.
- Uncontested latency:
  - Accept at cycle t.
  - Bus access at t+1; the CSR updates at the t+1 clock edge.
  - `rsp_valid` from t+2.
  - Next accept no earlier than the `rsp_ready` cycle +1.
- Contested latency: bus access occurs at t+1+k, where k ≤ MaxWait cycles lost to the core.
- `rsp_data` is the value read combinationally in the access cycle, i.e. the old value (CSRRW semantics). An `ext_write_enable` side effect in the same cycle does not alter the captured value.
- Response:
  - Back-to-back: `rsp_ready` held high gives a one-cycle `rsp_valid`.
  - Backpressure: `rsp_ready` low holds the response indefinitely; there is no timeout.
- Reset mid-operation: any latched or pending request is discarded without a response, and an in-flight bus drive stops the same cycle.

## Structure
- `decoder_pkg` already provides `csr_addr_t`, `csr_op_t`, `r` and `word`.
- Add `csr_req_t` to `decoder_pkg`: packed struct of addr, op, data, zimm, shared by host bridges.
- The FSM state enum (IDLE/PEND/RESP) is local to the module.
- Sub-module `csr_bus_mux`: a combinational 2:1 select of the core or host `csr_req_t` plus enable, driven by a `host_own` bit.

## Test plan
- Uncontested write:
  - Stimulus: CSRRW addr 0x305, data 0xDEAD_BEEF; CSR reset value 0x0000_0100; core idle.
  - Required: `csr_enable` at t+1; `rsp_data`=0x0000_0100 at t+2; CSR subsequently reads 0xDEAD_BEEF.
- Immediate clear:
  - Stimulus: CSRRCI zimm 5'b00011 on a CSR holding 0xF.
  - Required: `rsp_data`=0xF; CSR becomes 0xC.
- Starvation:
  - Stimulus: MaxWait=3, `core_csr_enable` held high for 10 cycles.
  - Required: host access in the 4th PEND cycle with `core_stall`=1 for exactly that cycle; all core accesses complete afterward.
- Illegal op:
  - Stimulus: `req_op` set to an undefined encoding.
  - Required: `rsp_err`=1, `rsp_data`=0 at t+1; `csr_enable` never asserted by the host.
- Backpressure:
  - Stimulus: `rsp_ready` low for 5 cycles, with `req_valid` held high.
  - Required: `rsp_valid` and `rsp_data` stable; `req_ready`=0 until the cycle after `rsp_ready`.
- Reset in PEND:
  - Stimulus: assert reset while the core is contesting the bus.
  - Required: `rsp_valid` never asserts; `req_ready`=1 after reset; the target CSR is unchanged.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared decoder types for the CSR bus: address/op/operand types and the
// request bundle used by every bridge that initiates CSR accesses.
package decoder_pkg;

  typedef logic [31:0] word;
  typedef logic [4:0]  r;
  typedef logic [11:0] csr_addr_t;

  // CSR op encoding follows the funct3 field; 000 and 100 are unused.
  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSRRW    = 3'b001,
    CSRRS    = 3'b010,
    CSRRC    = 3'b011,
    CSR_RSVD = 3'b100,
    CSRRWI   = 3'b101,
    CSRRSI   = 3'b110,
    CSRRCI   = 3'b111
  } csr_op_t;

  // One complete CSR access as seen on the shared bus.
  typedef struct packed {
    csr_addr_t addr;
    csr_op_t   op;
    word       data;
    r          zimm;
  } csr_req_t;

  // True for the six ops that perform a real CSR access.
  function automatic logic csr_op_legal(input csr_op_t op);
    case (op)
      CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_host_port_csr_bus_mux.sv
// 2:1 select between the core's CSR access and the host's latched access.
module csr_bus_mux
  import decoder_pkg::*;
(
  input  logic     i_host_own,
  input  logic     i_core_enable,
  input  csr_req_t i_core_req,
  input  csr_req_t i_host_req,
  output logic     o_enable,
  output csr_req_t o_req
);

  // Host fields win only in a host-owned cycle; otherwise the core passes through.
  always_comb begin
    o_enable = i_core_enable;
    o_req    = i_core_req;
    if (i_host_own) begin
      o_enable = 1'b1;
      o_req    = i_host_req;
    end else begin
      o_enable = i_core_enable;
      o_req    = i_core_req;
    end
  end

endmodule

// File: rtl/csr_host_port.sv
// Host-side CSR bus initiator: accepts one host request at a time, wins the
// bus when the core is idle or after MaxWait lost cycles (stalling the core),
// and returns the pre-access CSR value on a valid/ready response channel.
module csr_host_port
  import decoder_pkg::*;
#(
  parameter int MaxWait = 15
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      req_valid,
  output logic      req_ready,
  input  csr_addr_t req_addr,
  input  csr_op_t   req_op,
  input  word       req_data,
  input  r          req_zimm,
  output logic      rsp_valid,
  input  logic      rsp_ready,
  output word       rsp_data,
  output logic      rsp_err,
  input  logic      core_csr_enable,
  input  csr_addr_t core_csr_addr,
  input  csr_op_t   core_csr_op,
  input  r          core_rs1_zimm,
  input  word       core_rs1_data,
  output logic      csr_enable,
  output csr_addr_t csr_addr,
  output csr_op_t   csr_op,
  output r          rs1_zimm,
  output word       rs1_data,
  input  word       csr_rdata,
  output logic      core_stall
);

  // A zero MaxWait still needs a one-bit counter to compare against.
  localparam int              CntW    = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
  localparam logic [CntW-1:0] WaitMax = CntW'(MaxWait);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [CntW-1:0] r_wait;
  csr_req_t        r_req;
  word             r_rsp_data;
  logic            r_rsp_err;

  logic            w_host_own;
  logic            w_bus_enable;
  csr_req_t        w_core_req;
  csr_req_t        w_bus_req;

  // Reset is folded in so an in-flight host drive drops in the reset cycle itself.
  assign w_host_own = !reset && (r_state == S_PEND) &&
                      (!core_csr_enable || (r_wait == WaitMax));
  assign core_stall = w_host_own && core_csr_enable;

  assign w_core_req = '{addr: core_csr_addr, op: core_csr_op,
                        data: core_rs1_data, zimm: core_rs1_zimm};

  csr_bus_mux u_mux (
    .i_host_own    (w_host_own),
    .i_core_enable (core_csr_enable),
    .i_core_req    (w_core_req),
    .i_host_req    (r_req),
    .o_enable      (w_bus_enable),
    .o_req         (w_bus_req)
  );

  assign csr_enable = w_bus_enable;
  assign csr_addr   = w_bus_req.addr;
  assign csr_op     = w_bus_req.op;
  assign rs1_data   = w_bus_req.data;
  assign rs1_zimm   = w_bus_req.zimm;

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;

  // Request FSM: latch in IDLE, arbitrate in PEND, hold the response in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_req      <= '0;
      r_rsp_data <= 32'h0000_0000;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_req  <= '{addr: req_addr, op: req_op, data: req_data, zimm: req_zimm};
            r_wait <= '0;
            if (csr_op_legal(req_op)) begin
              r_state <= S_PEND;
            end else begin
              // Illegal op never touches the bus; answer immediately.
              r_state    <= S_RESP;
              r_rsp_data <= 32'h0000_0000;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        S_PEND: begin
          if (w_host_own) begin
            // csr_rdata is the combinational pre-write value of this access.
            r_rsp_data <= csr_rdata;
            r_rsp_err  <= 1'b0;
            r_state    <= S_RESP;
          end else if (r_wait != WaitMax) begin
            r_wait <= r_wait + CntW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
